md5_padder: RTL and testbench
=============================

MD5_PADDER -- requirements
Module: md5_padder

Interface
REQ-001 SHALL have parameter IN_W, default 32, input beat width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL have parameter LEN_W, default 64, message bit-length counter width; legal range 16..64.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, IN_W, message bytes; byte i at bits [8i+7:8i], little-endian.
REQ-006 SHALL have port in_bytes, input, $clog2(IN_W/8)+1, count of valid bytes in a last beat, 0..IN_W/8.
REQ-007 SHALL have port in_last, input, 1, marks the final beat of a message.
REQ-008 SHALL have port in_valid, input, 1, beat offered.
REQ-009 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-010 SHALL have port blk_data, output, 512, padded block; block byte k at bits [8k+7:8k].
REQ-011 SHALL have port blk_valid, output, 1, block offered.
REQ-012 SHALL have port blk_last, output, 1, final block of a message, qualified by blk_valid.
REQ-013 SHALL have port blk_ready, input, 1, block consumed when blk_valid && blk_ready.

Function
REQ-014 SHALL use states FILL, EMIT, TAIL; in_ready = (state == FILL).
REQ-015 SHALL, in FILL, write the accepted beat at byte pointer ptr (0..63) and add the beat's valid byte count to ptr and to the byte counter.
REQ-016 SHALL treat non-last beats as full (IN_W/8 bytes), ignoring in_bytes.
REQ-017 SHALL, when a non-last beat makes ptr reach 64, enter EMIT with blk_last=0 and reset ptr to 0.
REQ-018 SHALL, on a last beat with final fill p = ptr + in_bytes, proceed as follows.
- p <= 55: byte p = 0x80; bytes p+1..55 = 0; bytes 56..63 = length; EMIT with blk_last=1.
- 56 <= p <= 63: byte p = 0x80; remaining bytes = 0; EMIT with blk_last=0, then TAIL.
- p == 64: EMIT the full block with blk_last=0, then TAIL with byte 0 = 0x80.
REQ-019 SHALL, in TAIL, build a block of zeros (plus 0x80 at byte 0 when REQ-018 p == 64) with the length in bytes 56..63, and offer it with blk_last=1.
REQ-020 SHALL encode length = total message bytes × 8 as 64-bit little-endian, zero-extended from LEN_W; the counter wraps modulo 2^LEN_W.
REQ-021 SHALL hold blk_data and blk_last stable while blk_valid && !blk_ready.
REQ-022 SHALL, on the block handshake, clear the buffer and go to FILL (or TAIL per REQ-018); after blk_last, clear ptr and the byte counter.
REQ-023 SHALL accept the first beat of the next message in the cycle after the final block handshake; minimum latency is last-beat accept to blk_valid = 1 cycle.
REQ-024 SHALL accept a zero-length message (in_last with in_bytes=0 at ptr 0) and emit one block: 0x80 followed by zeros.
REQ-025 SHALL never have in_ready and blk_valid high together.

Reset
REQ-026 SHALL, on reset, immediately set state=FILL, ptr=0, counter=0, buffer=0, blk_valid=0, blk_last=0, in_ready=0; in_ready goes to 1 on the first clock after reset deasserts.
REQ-027 SHALL discard any partial message or pending block on mid-operation reset; no block is emitted for it.

Structure
REQ-028 SHALL place the block-width constant (512), the pad byte (8'h80), the length offset (56), and the state enum in shared package md5_pkg.
REQ-029 SHALL be a single module; the block buffer with byte-lane write enables stays inline, and no sub-module is required.

Verification
REQ-030 "Hashed" with IN_W=32: beats 32'h68736148, then 32'h00006465 with in_last and in_bytes=2 -> one block, bytes 0..6 = 48 61 73 68 65 64 80, byte 56 = 30, all other bytes 0, blk_last=1.
REQ-031 Empty message -> one block with byte 0 = 80, all others 0, blk_last=1.
REQ-032 56 bytes of 0xAA -> block 1 has byte 56 = 80 and blk_last=0; block 2 is all zero except byte 56 = C0, byte 57 = 01, blk_last=1.
REQ-033 64 bytes -> full data block with blk_last=0, then a block with byte 0 = 80, byte 57 = 02, blk_last=1.
REQ-034 blk_ready held low for 5 cycles while blk_valid -> blk_data stable and in_ready=0 throughout; exactly one handshake follows.
REQ-035 Reset after 3 beats, then "Hashed" -> output identical to REQ-030.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 message padder.
// Block geometry and pad values used by md5_padder and its bench.
package md5_pkg;

    localparam int BLK_W     = 512;
    localparam int BLK_BYTES = BLK_W / 8;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    localparam int LEN_OFF   = 56;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        TAIL = 2'd2
    } state_t;

endpackage

// File: rtl/md5_padder.sv
// MD5 padder: packs beats into 512-bit blocks, appends 0x80, zeros and the bit length; last beat to blk_valid is 1 cycle.
// Backpressure: a block is held stable until blk_ready; in_ready is low whenever a block is offered.
module md5_padder
    import md5_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int LEN_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_W-1:0]         in_data,
    input  logic [$clog2(IN_W/8):0] in_bytes,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BLK_W-1:0]        blk_data,
    output logic                    blk_valid,
    output logic                    blk_last,
    input  logic                    blk_ready
);

    localparam int BEAT_BYTES = IN_W / 8;

    state_t           state_q, state_d;
    logic [6:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0] bitlen_q, bitlen_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             tail_q, tail_d;
    logic             tail_pad_q, tail_pad_d;
    logic             last_q, last_d;
    logic             run_q;

    logic             acc;
    logic             hs;
    logic [6:0]       nb;
    logic [6:0]       p;
    logic [LEN_W-1:0] bitlen_add;
    logic [BLK_W-1:0] beat_blk;
    logic [BLK_W-1:0] tail_blk;

    assign in_ready   = (state_q == FILL) && run_q;
    assign blk_valid  = (state_q != FILL);
    assign blk_last   = last_q;
    assign blk_data   = blk_q;
    assign acc        = in_valid && in_ready;
    assign hs         = blk_valid && blk_ready;
    assign nb         = in_last ? 7'(in_bytes) : 7'(BEAT_BYTES);
    assign p          = ptr_q + nb;
    assign bitlen_add = bitlen_q + (LEN_W'(nb) << 3);

    // Byte-lane merge of the offered beat into the buffer, with pad and length on a last beat.
    always_comb begin
        logic [6:0] idx;
        idx      = '0;
        beat_blk = blk_q;
        for (int k = 0; k < BLK_BYTES; k++) begin
            idx = 7'(k) - ptr_q;
            if ((7'(k) >= ptr_q) && (idx < nb)) begin
                beat_blk[8*k +: 8] = 8'(in_data >> {idx, 3'b000});
            end
            if (in_last && (7'(k) == p)) begin
                beat_blk[8*k +: 8] = PAD_BYTE;
            end
        end
        if (in_last && (p <= 7'(LEN_OFF - 1))) begin
            beat_blk[8*LEN_OFF +: 64] = 64'(bitlen_add);
        end
    end

    always_comb begin
        tail_blk                  = '0;
        tail_blk[7:0]             = tail_pad_q ? PAD_BYTE : 8'h00;
        tail_blk[8*LEN_OFF +: 64] = 64'(bitlen_q);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bitlen_d   = bitlen_q;
        blk_d      = blk_q;
        tail_d     = tail_q;
        tail_pad_d = tail_pad_q;
        last_d     = last_q;
        case (state_q)
            FILL: begin
                if (acc) begin
                    blk_d    = beat_blk;
                    ptr_d    = p;
                    bitlen_d = bitlen_add;
                    if (in_last) begin
                        state_d    = EMIT;
                        last_d     = (p <= 7'(LEN_OFF - 1));
                        tail_d     = (p > 7'(LEN_OFF - 1));
                        tail_pad_d = (p == 7'(BLK_BYTES));
                    end else if (p == 7'(BLK_BYTES)) begin
                        state_d = EMIT;
                        ptr_d   = '0;
                    end
                end
            end
            EMIT: begin
                if (hs) begin
                    if (tail_q) begin
                        blk_d   = tail_blk;
                        state_d = TAIL;
                        last_d  = 1'b1;
                        tail_d  = 1'b0;
                    end else begin
                        blk_d   = '0;
                        state_d = FILL;
                        ptr_d   = '0;
                        if (last_q) begin
                            bitlen_d = '0;
                            last_d   = 1'b0;
                        end
                    end
                end
            end
            TAIL: begin
                if (hs) begin
                    blk_d      = '0;
                    state_d    = FILL;
                    ptr_d      = '0;
                    bitlen_d   = '0;
                    last_d     = 1'b0;
                    tail_pad_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            ptr_q      <= '0;
            bitlen_q   <= '0;
            blk_q      <= '0;
            tail_q     <= 1'b0;
            tail_pad_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            bitlen_q   <= bitlen_d;
            blk_q      <= blk_d;
            tail_q     <= tail_d;
            tail_pad_q <= tail_pad_d;
            last_q     <= last_d;
        end
    end

    // Holds in_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder (IN_W=32): each task drives one scenario and checks inline.
module tb_md5_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    md5_padder #(.IN_W(32), .LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    function automatic logic [511:0] exp_hashed();
        logic [511:0] e;
        e = '0;
        e[7:0]   = 8'h48; e[15:8]  = 8'h61; e[23:16] = 8'h73; e[31:24] = 8'h68;
        e[39:32] = 8'h65; e[47:40] = 8'h64; e[55:48] = 8'h80;
        e[8*56 +: 8] = 8'h30;
        return e;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int t;
        @(negedge clk);
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv_block(output logic [511:0] d, output logic l);
        int t;
        blk_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!blk_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            $display("FAIL recv_timeout: blk_valid=%b after %0d cycles, required 1", blk_valid, t);
            d = '0;
            l = 1'b0;
        end else begin
            d = blk_data;
            l = blk_last;
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic send_hashed();
        send_beat(32'h68736148, 3'd4, 1'b0);
        send_beat(32'h00006465, 3'd2, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0 || blk_last !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_ctrl: valid=%b last=%b in_ready=%b, required 0 0 0", blk_valid, blk_last, in_ready);
        else passed++;
        checks++;
        if (blk_data !== 512'h0) $display("FAIL reset_data: got %h, required 0", blk_data);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_release: in_ready=%b before first edge, required 0", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b after first edge, required 1", in_ready);
        else passed++;
    endtask

    task automatic test_hashed();
        logic [511:0] d;
        logic l;
        send_hashed();
        checks++;
        if (blk_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL hashed_latency: valid=%b in_ready=%b one cycle after last beat, required 1 0", blk_valid, in_ready);
        else passed++;
        recv_block(d, l);
        checks++;
        if (d !== exp_hashed()) $display("FAIL hashed_data: got %h, required %h", d, exp_hashed());
        else passed++;
        checks++;
        if (l !== 1'b1) $display("FAIL hashed_last: got %b, required 1", l);
        else passed++;
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0)
            $display("FAIL hashed_next_ready: in_ready=%b valid=%b after handshake, required 1 0", in_ready, blk_valid);
        else passed++;
    endtask

    task automatic test_empty();
        logic [511:0] d, e;
        logic l;
        e = '0;
        e[7:0] = 8'h80;
        send_beat(32'hDEADBEEF, 3'd0, 1'b1);
        recv_block(d, l);
        checks++;
        if (d !== e) $display("FAIL empty_data: got %h, required %h", d, e);
        else passed++;
        checks++;
        if (l !== 1'b1) $display("FAIL empty_last: got %b, required 1", l);
        else passed++;
    endtask

    task automatic test_56_bytes();
        logic [511:0] d1, d2, e1, e2;
        logic l1, l2;
        e1 = '0;
        for (int k = 0; k < 56; k++) e1[8*k +: 8] = 8'hAA;
        e1[8*56 +: 8] = 8'h80;
        e2 = '0;
        e2[8*56 +: 8] = 8'hC0;
        e2[8*57 +: 8] = 8'h01;
        for (int i = 0; i < 13; i++) send_beat(32'hAAAAAAAA, 3'd4, 1'b0);
        send_beat(32'hAAAAAAAA, 3'd4, 1'b1);
        recv_block(d1, l1);
        recv_block(d2, l2);
        checks++;
        if (d1 !== e1) $display("FAIL b56_blk1_data: got %h, required %h", d1, e1);
        else passed++;
        checks++;
        if (l1 !== 1'b0) $display("FAIL b56_blk1_last: got %b, required 0", l1);
        else passed++;
        checks++;
        if (d2 !== e2) $display("FAIL b56_blk2_data: got %h, required %h", d2, e2);
        else passed++;
        checks++;
        if (l2 !== 1'b1) $display("FAIL b56_blk2_last: got %b, required 1", l2);
        else passed++;
    endtask

    task automatic test_64_bytes();
        logic [511:0] d1, d2, e1, e2;
        logic l1, l2;
        logic [31:0] w;
        e1 = '0;
        for (int k = 0; k < 64; k++) e1[8*k +: 8] = 8'(k);
        e2 = '0;
        e2[7:0] = 8'h80;
        e2[8*57 +: 8] = 8'h02;
        for (int i = 0; i < 16; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            send_beat(w, 3'd4, (i == 15));
        end
        recv_block(d1, l1);
        recv_block(d2, l2);
        checks++;
        if (d1 !== e1) $display("FAIL b64_blk1_data: got %h, required %h", d1, e1);
        else passed++;
        checks++;
        if (l1 !== 1'b0) $display("FAIL b64_blk1_last: got %b, required 0", l1);
        else passed++;
        checks++;
        if (d2 !== e2) $display("FAIL b64_blk2_data: got %h, required %h", d2, e2);
        else passed++;
        checks++;
        if (l2 !== 1'b1) $display("FAIL b64_blk2_last: got %b, required 1", l2);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [511:0] held;
        blk_ready = 1'b0;
        send_hashed();
        @(negedge clk);
        held = blk_data;
        checks++;
        if (held !== exp_hashed() || blk_valid !== 1'b1)
            $display("FAIL bp_block: valid=%b data=%h, required 1 %h", blk_valid, held, exp_hashed());
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (blk_data !== held || blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_last !== 1'b1)
                $display("FAIL bp_hold_%0d: stable=%b valid=%b in_ready=%b last=%b, required 1 1 0 1",
                         i, (blk_data === held), blk_valid, in_ready, blk_last);
            else passed++;
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_single_handshake: valid=%b in_ready=%b, required 0 1", blk_valid, in_ready);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [511:0] d;
        logic l;
        for (int i = 0; i < 3; i++) send_beat(32'h11223344, 3'd4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b0 || blk_data !== 512'h0)
            $display("FAIL midrst_state: valid=%b in_ready=%b data_zero=%b, required 0 0 1",
                     blk_valid, in_ready, (blk_data === 512'h0));
        else passed++;
        reset = 1'b0;
        send_hashed();
        recv_block(d, l);
        checks++;
        if (d !== exp_hashed()) $display("FAIL midrst_data: got %h, required %h", d, exp_hashed());
        else passed++;
        checks++;
        if (l !== 1'b1) $display("FAIL midrst_last: got %b, required 1", l);
        else passed++;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) $display("FAIL midrst_extra_block: valid=%b, required 0", blk_valid);
        else passed++;
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = '0;
        in_bytes  = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        blk_ready = 1'b0;
        test_reset();
        test_hashed();
        test_empty();
        test_56_bytes();
        test_64_bytes();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
